load_store_unit: RTL and testbench

Parametrised load/store unit for the MEM stage of the pipelined core, replacing the inline byte-enable and direct-BRAM data path. It accepts one access per instruction from EX/MEM and performs a req/ack transaction on a variable-latency data bus. It generates lane-aligned byte enables and write data, and returns sign- or zero-extended load data. It stalls the pipeline until the access completes, is rejected as misaligned, or times out.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 47 ++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: load/store FSM states and RISC-V load/store funct3 size codes.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_HALF  = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_DWORD = 3'b011;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_HALFU = 3'b101;
    localparam logic [2:0] F3_WORDU = 3'b110;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit: byte enables, store data
// shift, alignment/legality check, and load data shift plus sign/zero extension.
module lsu_lane_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 funct3,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [XLEN-1:0]            wdata,
    input  logic [XLEN-1:0]            rdata,
    output logic [XLEN/8-1:0]          be,
    output logic [XLEN-1:0]            wdata_lane,
    output logic                       fault,
    output logic [XLEN-1:0]            rdata_ext
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    logic [1:0]      size;
    logic            illegal;
    logic [OW-1:0]   align_mask;
    logic [NB-1:0]   size_mask;
    logic [XLEN-1:0] rdata_sh;
    logic [XLEN-1:0] bit_mask;
    logic            sign_bit;

    // Decode size, check legality/alignment, and steer data to/from byte lanes
    always_comb begin
        size       = funct3[1:0];
        illegal    = (funct3 == 3'b111) ||
                     ((XLEN == 32) && ((funct3 == F3_DWORD) || (funct3 == F3_WORDU)));
        align_mask = OW'((4'd1 << size) - 4'd1);
        fault      = illegal | (|(off & align_mask));
        size_mask  = ~({NB{1'b1}} << (4'd1 << size));
        be         = size_mask << off;
        wdata_lane = wdata << {off, 3'b000};
        rdata_sh   = rdata >> {off, 3'b000};
        // bit_mask covers the access width; its top bit is the sign position
        bit_mask   = ~({XLEN{1'b1}} << (7'd8 << size));
        sign_bit   = |(rdata_sh & bit_mask & ~(bit_mask >> 1));
        rdata_ext  = (rdata_sh & bit_mask) |
                     ((~funct3[2] & sign_bit) ? ~bit_mask : '0);
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: req/ack bus transaction with lane-aligned data and
// pipeline stall. Optional ACCESS wait timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ALEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              misalign,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ALEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    lsu_state_t      state;
    logic [2:0]      lat_funct3;
    logic [OW-1:0]   lat_off;
    logic [2:0]      sel_funct3;
    logic [OW-1:0]   sel_off;
    logic [NB-1:0]   lane_be;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] lane_rdata;
    logic            lane_fault;
    logic            timed_out;

    // In IDLE the aligner sees the incoming request; afterwards the latched copy
    always_comb begin
        sel_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
        sel_off    = (state == IDLE) ? req_addr[OW-1:0] : lat_off;
    end

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .funct3     (sel_funct3),
        .off        (sel_off),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .fault      (lane_fault),
        .rdata_ext  (lane_rdata)
    );

    assign stall = req_valid & (state != RESP);

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [CW-1:0] wait_cnt;

    // Count ACCESS cycles without ack; held at zero while IDLE so each access starts fresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !mem_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT >= 1);
    assign timed_out      = 1'b0;
`endif

    // Access FSM with registered bus and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_funct3 <= '0;
            lat_off    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (lane_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            misalign   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state      <= ACCESS;
                            lat_funct3 <= req_funct3;
                            lat_off    <= req_addr[OW-1:0];
                            mem_req    <= 1'b1;
                            mem_we     <= req_we;
                            mem_addr   <= {req_addr[ALEN-1:OW], {OW{1'b0}}};
                            mem_be     <= lane_be;
                            mem_wdata  <= lane_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= mem_we ? '0 : lane_rdata;
                    end else if (timed_out) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        bus_err    <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a 32-bit and a 64-bit instance driven
// from a directed vector table, plus hand-written multi-cycle sequences.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        s32_req_valid, s32_req_we, s32_stall, s32_resp_valid, s32_misalign, s32_bus_err;
    logic        s32_mem_req, s32_mem_we, s32_mem_ack;
    logic [2:0]  s32_req_funct3;
    logic [31:0] s32_req_addr, s32_req_wdata, s32_resp_rdata, s32_mem_addr, s32_mem_wdata, s32_mem_rdata;
    logic [3:0]  s32_mem_be;

    // 64-bit instance signals
    logic        s64_req_valid, s64_req_we, s64_stall, s64_resp_valid, s64_misalign, s64_bus_err;
    logic        s64_mem_req, s64_mem_we, s64_mem_ack;
    logic [2:0]  s64_req_funct3;
    logic [31:0] s64_req_addr, s64_mem_addr;
    logic [63:0] s64_req_wdata, s64_resp_rdata, s64_mem_wdata, s64_mem_rdata;
    logic [7:0]  s64_mem_be;

    load_store_unit #(.XLEN(32), .ALEN(32), .TIMEOUT(15)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(s32_req_valid), .req_we(s32_req_we), .req_funct3(s32_req_funct3),
        .req_addr(s32_req_addr), .req_wdata(s32_req_wdata),
        .stall(s32_stall), .resp_valid(s32_resp_valid), .resp_rdata(s32_resp_rdata),
        .misalign(s32_misalign), .bus_err(s32_bus_err),
        .mem_req(s32_mem_req), .mem_we(s32_mem_we), .mem_addr(s32_mem_addr),
        .mem_be(s32_mem_be), .mem_wdata(s32_mem_wdata),
        .mem_ack(s32_mem_ack), .mem_rdata(s32_mem_rdata)
    );

    load_store_unit #(.XLEN(64), .ALEN(32), .TIMEOUT(15)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(s64_req_valid), .req_we(s64_req_we), .req_funct3(s64_req_funct3),
        .req_addr(s64_req_addr), .req_wdata(s64_req_wdata),
        .stall(s64_stall), .resp_valid(s64_resp_valid), .resp_rdata(s64_resp_rdata),
        .misalign(s64_misalign), .bus_err(s64_bus_err),
        .mem_req(s64_mem_req), .mem_we(s64_mem_we), .mem_addr(s64_mem_addr),
        .mem_be(s64_mem_be), .mem_wdata(s64_mem_wdata),
        .mem_ack(s64_mem_ack), .mem_rdata(s64_mem_rdata)
    );

    typedef struct {
        bit          is64;
        bit          we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          ack_dly;
        int          resp_cyc;
        bit          fault;
        logic [63:0] exp_addr;
        logic [63:0] exp_be;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Sampled outputs of whichever instance is under test
    logic        smp_stall, smp_req, smp_we, smp_rv, smp_mis, smp_berr;
    logic [63:0] smp_addr, smp_be, smp_wdata, smp_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input bit is64, input bit we, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata, input int ack_dly, input int resp_cyc,
                                input bit fault, input logic [63:0] exp_addr,
                                input logic [63:0] exp_be, input logic [63:0] exp_wdata,
                                input logic [63:0] exp_rdata);
        vec_t v;
        v.is64 = is64; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.ack_dly = ack_dly; v.resp_cyc = resp_cyc; v.fault = fault; v.exp_addr = exp_addr;
        v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic drive(input bit is64, input bit valid, input bit we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input bit ack);
        if (is64) begin
            s64_req_valid = valid; s64_req_we = we; s64_req_funct3 = f3;
            s64_req_addr = addr[31:0]; s64_req_wdata = wdata; s64_mem_rdata = rdata;
            s64_mem_ack = ack;
        end else begin
            s32_req_valid = valid; s32_req_we = we; s32_req_funct3 = f3;
            s32_req_addr = addr[31:0]; s32_req_wdata = wdata[31:0]; s32_mem_rdata = rdata[31:0];
            s32_mem_ack = ack;
        end
    endtask

    task automatic sample(input bit is64);
        if (is64) begin
            smp_stall = s64_stall; smp_req = s64_mem_req; smp_we = s64_mem_we;
            smp_rv = s64_resp_valid; smp_mis = s64_misalign; smp_berr = s64_bus_err;
            smp_addr = 64'(s64_mem_addr); smp_be = 64'(s64_mem_be);
            smp_wdata = s64_mem_wdata; smp_rdata = s64_resp_rdata;
        end else begin
            smp_stall = s32_stall; smp_req = s32_mem_req; smp_we = s32_mem_we;
            smp_rv = s32_resp_valid; smp_mis = s32_misalign; smp_berr = s32_bus_err;
            smp_addr = 64'(s32_mem_addr); smp_be = 64'(s32_mem_be);
            smp_wdata = 64'(s32_mem_wdata); smp_rdata = 64'(s32_resp_rdata);
        end
    endtask

    // Apply one vector starting in an IDLE cycle (just after a rising edge)
    task automatic run_vec(input vec_t v, input int idx);
        int          stall_n  = 0;
        bit          req_seen = 1'b0;
        bit          got      = 1'b0;
        logic [63:0] a = '0, b = '0, w = '0, we = '0;
        for (int cyc = 0; cyc < 40 && !got; cyc++) begin
            drive(v.is64, 1'b1, v.we, v.f3, v.addr, v.wdata, v.rdata, (cyc == 1 + v.ack_dly));
            @(negedge clk);
            sample(v.is64);
            if (smp_stall) stall_n++;
            if (smp_req) req_seen = 1'b1;
            if (cyc == 1) begin a = smp_addr; b = smp_be; w = smp_wdata; we = 64'(smp_we); end
            if (smp_rv) begin
                got = 1'b1;
                chk($sformatf("v%0d resp_cycle", idx), 64'(cyc), 64'(v.resp_cyc));
                chk($sformatf("v%0d resp_rdata", idx), smp_rdata, v.exp_rdata);
                chk($sformatf("v%0d misalign", idx), 64'(smp_mis), 64'(v.fault));
                chk($sformatf("v%0d bus_err", idx), 64'(smp_berr), 64'd0);
                chk($sformatf("v%0d mem_req_in_resp", idx), 64'(smp_req), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        drive(v.is64, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b0);
        if (!got) chk($sformatf("v%0d resp_seen", idx), 64'd0, 64'd1);
        chk($sformatf("v%0d stall_cycles", idx), 64'(stall_n), 64'(v.resp_cyc));
        chk($sformatf("v%0d mem_req_seen", idx), 64'(req_seen), 64'(!v.fault));
        if (!v.fault) begin
            chk($sformatf("v%0d mem_addr", idx), a, v.exp_addr);
            chk($sformatf("v%0d mem_be", idx), b, v.exp_be);
            chk($sformatf("v%0d mem_wdata", idx), w, v.exp_wdata);
            chk($sformatf("v%0d mem_we", idx), we, 64'(v.we));
        end
    endtask

    initial begin
        bit   got;
        int   rc;
        logic berr, req_mid, seen_rv, seen_req, st1;
        logic [63:0] rd;

        // SB/LB/LBU/LW/LH/LHU/SH/SW, faults, then 64-bit LD/LWU/LW/SD/SB/LH
        vecs.push_back(mk(0, 1, 3'b000, 64'h103, 64'hAB, 64'h0, 0, 2, 0, 64'h100, 64'h8, 64'hAB000000, 64'h0));
        vecs.push_back(mk(0, 0, 3'b000, 64'h102, 64'h0, 64'h00800000, 0, 2, 0, 64'h100, 64'h4, 64'h0, 64'hFFFFFF80));
        vecs.push_back(mk(0, 0, 3'b100, 64'h102, 64'h0, 64'h00800000, 0, 2, 0, 64'h100, 64'h4, 64'h0, 64'h00000080));
        vecs.push_back(mk(0, 0, 3'b010, 64'h101, 64'h0, 64'h0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 64'h0));
        vecs.push_back(mk(0, 0, 3'b001, 64'h106, 64'h0, 64'h80011234, 1, 3, 0, 64'h104, 64'hC, 64'h0, 64'hFFFF8001));
        vecs.push_back(mk(0, 0, 3'b101, 64'h106, 64'h0, 64'h80011234, 0, 2, 0, 64'h104, 64'hC, 64'h0, 64'h00008001));
        vecs.push_back(mk(0, 1, 3'b001, 64'h102, 64'hBEEF, 64'h0, 0, 2, 0, 64'h100, 64'hC, 64'hBEEF0000, 64'h0));
        vecs.push_back(mk(0, 1, 3'b010, 64'h200, 64'hDEADBEEF, 64'hFFFFFFFF, 2, 4, 0, 64'h200, 64'hF, 64'hDEADBEEF, 64'h0));
        vecs.push_back(mk(0, 0, 3'b010, 64'h20C, 64'h0, 64'h80000000, 0, 2, 0, 64'h20C, 64'hF, 64'h0, 64'h80000000));
        vecs.push_back(mk(0, 0, 3'b011, 64'h100, 64'h0, 64'h0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 64'h0));
        vecs.push_back(mk(0, 0, 3'b111, 64'h100, 64'h0, 64'h0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 64'h0));
        vecs.push_back(mk(0, 1, 3'b001, 64'h101, 64'h1234, 64'h0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 64'h0));
        vecs.push_back(mk(0, 0, 3'b000, 64'h101, 64'h0, 64'h00007F00, 0, 2, 0, 64'h100, 64'h2, 64'h0, 64'h0000007F));
        vecs.push_back(mk(1, 0, 3'b011, 64'h08, 64'h0, 64'h0123456789ABCDEF, 3, 5, 0, 64'h08, 64'hFF, 64'h0, 64'h0123456789ABCDEF));
        vecs.push_back(mk(1, 0, 3'b110, 64'h0C, 64'h0, 64'h89ABCDEF00000000, 0, 2, 0, 64'h08, 64'hF0, 64'h0, 64'h0000000089ABCDEF));
        vecs.push_back(mk(1, 0, 3'b010, 64'h0C, 64'h0, 64'h89ABCDEF00000000, 0, 2, 0, 64'h08, 64'hF0, 64'h0, 64'hFFFFFFFF89ABCDEF));
        vecs.push_back(mk(1, 1, 3'b011, 64'h10, 64'h1122334455667788, 64'h0, 0, 2, 0, 64'h10, 64'hFF, 64'h1122334455667788, 64'h0));
        vecs.push_back(mk(1, 0, 3'b011, 64'h0C, 64'h0, 64'h0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 64'h0));
        vecs.push_back(mk(1, 1, 3'b000, 64'h0F, 64'h5A, 64'h0, 0, 2, 0, 64'h08, 64'h80, 64'h5A00000000000000, 64'h0));
        vecs.push_back(mk(1, 0, 3'b001, 64'h0A, 64'h0, 64'h00000000FFFE0000, 1, 3, 0, 64'h08, 64'h0C, 64'h0, 64'hFFFFFFFFFFFFFFFE));

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b0);
        #12;
        chk("reset s32 mem_req", 64'(s32_mem_req), 64'd0);
        chk("reset s32 resp_valid", 64'(s32_resp_valid), 64'd0);
        chk("reset s32 bus_fields", {s32_mem_addr, s32_mem_wdata}, 64'd0);
        chk("reset s32 be_rdata_flags", {24'd0, s32_mem_be, s32_resp_rdata, s32_misalign, s32_bus_err, s32_mem_we, s32_stall}, 64'd0);
        chk("reset s64 outputs", {s64_mem_be, s64_mem_addr, 20'd0, s64_mem_req, s64_resp_valid, s64_mem_we, s64_stall}, 64'd0);
        chk("reset s64 data", s64_mem_wdata | s64_resp_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Vectors are applied back to back: each starts in the cycle after the previous RESP
        foreach (vecs[i]) run_vec(vecs[i], i);

        // mem_ack while idle must not start or complete anything
        seen_rv = 1'b0; seen_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            s32_mem_ack = 1'b1;
            @(negedge clk);
            if (s32_resp_valid) seen_rv = 1'b1;
            if (s32_mem_req) seen_req = 1'b1;
            @(posedge clk);
            #1;
        end
        s32_mem_ack = 1'b0;
        chk("idle_ack resp_valid", 64'(seen_rv), 64'd0);
        chk("idle_ack mem_req", 64'(seen_req), 64'd0);

        // No ack: times out at cycle 16 when enabled, otherwise waits and completes on late ack
        got = 1'b0; rc = -1; berr = 1'b0; rd = '0; req_mid = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            drive(1'b0, 1'b1, 1'b0, 3'b010, 64'h100, 64'h0, 64'hCAFEF00D, (!TO_EN && c == 22));
            @(negedge clk);
            if (c == 10) req_mid = s32_mem_req;
            if (s32_resp_valid) begin
                got = 1'b1; rc = c; berr = s32_bus_err; rd = 64'(s32_resp_rdata);
            end
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b0);
        chk("long_wait mem_req_mid", 64'(req_mid), 64'd1);
        chk("long_wait resp_cycle", 64'(rc), TO_EN ? 64'd16 : 64'd23);
        chk("long_wait bus_err", 64'(berr), 64'(TO_EN));
        chk("long_wait resp_rdata", rd, TO_EN ? 64'd0 : 64'hCAFEF00D);

        // Reset in the middle of ACCESS: mem_req drops at once, no response ever follows
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b1, 1'b0, 3'b010, 64'h100, 64'h0, 64'h0, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("rst_mid mem_req_before", 64'(s32_mem_req), 64'd1);
        #2;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b0);
        #1;
        chk("rst_mid mem_req_async", 64'(s32_mem_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_rv = 1'b0; seen_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s32_resp_valid) seen_rv = 1'b1;
            if (s32_mem_req) seen_req = 1'b1;
        end
        chk("rst_mid no_resp", 64'(seen_rv), 64'd0);
        chk("rst_mid no_req", 64'(seen_req), 64'd0);
        @(posedge clk);
        #1;

        // req_valid dropped mid-ACCESS: the latched store still completes
        got = 1'b0; rc = -1; st1 = 1'b1; berr = 1'b0; rd = '1;
        for (int c = 0; c < 10 && !got; c++) begin
            drive(1'b0, (c == 0), 1'b1, 3'b010, 64'h300, 64'h12345678, 64'hFFFFFFFF, (c == 2));
            @(negedge clk);
            if (c == 1) st1 = s32_stall;
            if (c == 2) rd = 64'(s32_mem_wdata);
            if (s32_resp_valid) begin got = 1'b1; rc = c; berr = s32_misalign; end
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b0);
        chk("drop_valid stall", 64'(st1), 64'd0);
        chk("drop_valid mem_wdata", rd, 64'h12345678);
        chk("drop_valid resp_cycle", 64'(rc), 64'd3);
        chk("drop_valid misalign", 64'(berr), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
